// File: rtl/ex_mem_skid_reg_pkg.sv
// ============================================================================
// Module   : ex_mem_skid_reg_pkg
// Purpose  : Shared definitions for the EX->MEM skid register. Holds the
//            default widths, the RV32 opcode constants, the occupancy state
//            encoding, and helper functions that compute the width and field
//            offsets of the packed per-entry payload vector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mem_skid_reg_pkg;

    localparam int DEF_XLEN      = 32;
    localparam int DEF_REG_IDX_W = 5;
    localparam int DEF_OPC_W     = 7;

    // Base RV32I opcodes seen crossing the EX->MEM boundary
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // The state value is the number of entries held, so it doubles as the
    // occupancy output.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // Payload layout, LSB first:
    //   regwrite | opcode | rs2 | rs1 | rd | alu_result | r2 | imm | instr
    localparam int OFF_REGWRITE = 0;

    function automatic int payload_w(input int xlen, input int ridx, input int opc);
        return 3*xlen + xlen + 3*ridx + opc + 1;
    endfunction

    function automatic int off_opcode();
        return 1;
    endfunction

    function automatic int off_rs2(input int opc);
        return 1 + opc;
    endfunction

    function automatic int off_rs1(input int ridx, input int opc);
        return 1 + opc + ridx;
    endfunction

    function automatic int off_rd(input int ridx, input int opc);
        return 1 + opc + 2*ridx;
    endfunction

    function automatic int off_alu(input int ridx, input int opc);
        return 1 + opc + 3*ridx;
    endfunction

    function automatic int off_r2(input int xlen, input int ridx, input int opc);
        return 1 + opc + 3*ridx + xlen;
    endfunction

    function automatic int off_imm(input int xlen, input int ridx, input int opc);
        return 1 + opc + 3*ridx + 2*xlen;
    endfunction

    function automatic int off_instr(input int xlen, input int ridx, input int opc);
        return 1 + opc + 3*ridx + 3*xlen;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_skid_reg_if.sv
// ============================================================================
// Module   : ex_mem_skid_reg_if
// Purpose  : Valid/ready pipeline bus carrying one EX-stage instruction.
//            The master drives valid and payload; the slave drives ready.
// Signals  : valid, ready, instr, imm, r2, alu_result (XLEN),
//            rd, rs1, rs2 (REG_IDX_W), opcode (OPC_W), regwrite
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_mem_skid_reg_if
    import ex_mem_skid_reg_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int REG_IDX_W = DEF_REG_IDX_W,
    parameter int OPC_W     = DEF_OPC_W
);
    logic                 valid;
    logic                 ready;
    logic [XLEN-1:0]      instr;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      r2;
    logic [XLEN-1:0]      alu_result;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [OPC_W-1:0]     opcode;
    logic                 regwrite;

    modport master (
        output valid, instr, imm, r2, alu_result, rd, rs1, rs2, opcode, regwrite,
        input  ready
    );

    modport slave (
        input  valid, instr, imm, r2, alu_result, rd, rs1, rs2, opcode, regwrite,
        output ready
    );

endinterface

`default_nettype wire

// File: rtl/ex_mem_skid_reg_stage_payload.sv
// ============================================================================
// Module   : ex_mem_skid_reg_stage_payload
// Purpose  : Enable-loaded vector register holding one packed pipeline entry.
//            Clears to zero on asynchronous reset, otherwise holds until load.
// Ports    : clk, reset (async, active-high), load, d[W], q[W]
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_skid_reg_stage_payload #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_skid_reg.sv
// ============================================================================
// Module   : ex_mem_skid_reg
// Purpose  : EX->MEM pipeline boundary register with valid/ready handshake,
//            2-entry skid buffer (main + skid), synchronous flush, x0-write
//            suppression and a forwarding tap off the head entry.
//            in_ready is a register, so out_ready has no combinational path
//            to in_ready.
// Ports    : clk, reset (async, active-high), flush (sync)
//            ex_if  (slave)  - instruction from the EX stage
//            mem_if (master) - head entry towards the MEM stage
//            fwd_valid, fwd_rd, fwd_data - forwarding tap
//            occupancy[1:0] - entries held, 0..2
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_skid_reg
    import ex_mem_skid_reg_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int REG_IDX_W = DEF_REG_IDX_W,
    parameter int OPC_W     = DEF_OPC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    ex_mem_skid_reg_if.slave     ex_if,
    ex_mem_skid_reg_if.master    mem_if,
    output logic                 fwd_valid,
    output logic [REG_IDX_W-1:0] fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic [1:0]           occupancy
);

    localparam int PAYLOAD_W = payload_w(XLEN, REG_IDX_W, OPC_W);
    localparam int OFF_OPC   = off_opcode();
    localparam int OFF_RS2   = off_rs2(OPC_W);
    localparam int OFF_RS1   = off_rs1(REG_IDX_W, OPC_W);
    localparam int OFF_RD    = off_rd(REG_IDX_W, OPC_W);
    localparam int OFF_ALU   = off_alu(REG_IDX_W, OPC_W);
    localparam int OFF_R2    = off_r2(XLEN, REG_IDX_W, OPC_W);
    localparam int OFF_IMM   = off_imm(XLEN, REG_IDX_W, OPC_W);
    localparam int OFF_INSTR = off_instr(XLEN, REG_IDX_W, OPC_W);

    skid_state_t          r_state;
    logic                 r_out_valid;
    logic                 r_in_ready;

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_main_load;
    logic                 w_skid_load;
    logic [PAYLOAD_W-1:0] w_in_payload;
    logic [PAYLOAD_W-1:0] w_main_d;
    logic [PAYLOAD_W-1:0] w_main_q;
    logic [PAYLOAD_W-1:0] w_skid_q;
    logic                 w_out_regwrite;

    assign w_in_fire  = ex_if.valid & r_in_ready;
    assign w_out_fire = r_out_valid & mem_if.ready;

    // A write to x0 is architecturally a no-op, so it is stripped on capture
    // and never reaches the MEM stage or the forwarding network.
    assign w_in_payload = {ex_if.instr, ex_if.imm, ex_if.r2, ex_if.alu_result,
                           ex_if.rd, ex_if.rs1, ex_if.rs2, ex_if.opcode,
                           ex_if.regwrite & (ex_if.rd != '0)};

    // Payload enables. Flush suppresses every load so the flushed-cycle input
    // is dropped; stale payload is harmless because valids are cleared.
    always_comb begin
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        w_main_d    = w_in_payload;
        if (!flush) begin
            case (r_state)
                SKID_EMPTY: begin
                    w_main_load = w_in_fire;
                end
                SKID_ONE: begin
                    w_main_load = w_in_fire & w_out_fire;
                    w_skid_load = w_in_fire & ~w_out_fire;
                end
                SKID_TWO: begin
                    // in_ready is low here, so only the skid entry can advance
                    w_main_load = w_out_fire;
                    w_main_d    = w_skid_q;
                end
                default: begin
                    w_main_load = 1'b0;
                end
            endcase
        end
    end

    // Occupancy FSM with registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SKID_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= SKID_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= SKID_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        r_state    <= SKID_TWO;
                        r_in_ready <= 1'b0;
                    end else if (!w_in_fire && w_out_fire) begin
                        r_state     <= SKID_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                SKID_TWO: begin
                    if (w_out_fire) begin
                        r_state    <= SKID_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= SKID_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    ex_mem_skid_reg_stage_payload #(
        .W (PAYLOAD_W)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (w_main_load),
        .d     (w_main_d),
        .q     (w_main_q)
    );

    ex_mem_skid_reg_stage_payload #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (w_skid_load),
        .d     (w_in_payload),
        .q     (w_skid_q)
    );

    assign w_out_regwrite = w_main_q[OFF_REGWRITE] & r_out_valid;

    assign ex_if.ready       = r_in_ready;
    assign mem_if.valid      = r_out_valid;
    assign mem_if.instr      = w_main_q[OFF_INSTR +: XLEN];
    assign mem_if.imm        = w_main_q[OFF_IMM   +: XLEN];
    assign mem_if.r2         = w_main_q[OFF_R2    +: XLEN];
    assign mem_if.alu_result = w_main_q[OFF_ALU   +: XLEN];
    assign mem_if.rd         = w_main_q[OFF_RD    +: REG_IDX_W];
    assign mem_if.rs1        = w_main_q[OFF_RS1   +: REG_IDX_W];
    assign mem_if.rs2        = w_main_q[OFF_RS2   +: REG_IDX_W];
    assign mem_if.opcode     = w_main_q[OFF_OPC   +: OPC_W];
    assign mem_if.regwrite   = w_out_regwrite;

    assign fwd_valid = w_out_regwrite;
    assign fwd_rd    = w_main_q[OFF_RD  +: REG_IDX_W];
    assign fwd_data  = w_main_q[OFF_ALU +: XLEN];
    assign occupancy = r_state;

endmodule

`default_nettype wire
